multicycle_control_fsm: RTL

- Main sequencing controller for the multi-cycle MIPS-style datapath.
- Decodes the 6-bit opcode and walks each instruction through fetch, decode, execute, memory and writeback states.
- Drives datapath enables and muxes, plus the 2-bit alu_op consumed by the ALU control unit (00 add, 01 subtract, 10 funct-decoded).
- Memory accesses use a ready handshake with a timeout counter.

---
 rtl/multicycle_control_fsm.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_fsm.sv
// Main sequencing controller for the multi-cycle MIPS-style datapath.
// Walks each instruction through fetch/decode/execute/memory/writeback,
// drives datapath enables and mux selects, and guards every memory access
// with a ready handshake plus an optional timeout counter.
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT = 16,
  parameter int STATE_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic               instr_done,
  output logic               illegal_op,
  output logic               mem_error,
  output logic [STATE_W-1:0] state_dbg
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Counter only needs to reach MEM_TIMEOUT-1.
  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TMO_LAST = (MEM_TIMEOUT > 0) ? CNT_W'(MEM_TIMEOUT - 1) : '0;

  typedef enum logic [STATE_W-1:0] {
    FETCH      = STATE_W'(0),
    DECODE     = STATE_W'(1),
    MEM_ADDR   = STATE_W'(2),
    MEM_READ   = STATE_W'(3),
    MEM_WB     = STATE_W'(4),
    MEM_WRITE  = STATE_W'(5),
    EXECUTE    = STATE_W'(6),
    R_COMPLETE = STATE_W'(7),
    BRANCH     = STATE_W'(8),
    JUMP       = STATE_W'(9)
  } state_t;

  state_t           state_r;
  state_t           next_state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             mem_state_s;
  logic             tmo_s;

  assign state_dbg = state_r;

  // State register and memory-wait counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= FETCH;
      cnt_r   <= '0;
    end else begin
      state_r <= next_state_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Timeout detection: fires only when the wait budget is spent and ready is still low.
  always_comb begin
    mem_state_s = 1'b0;
    tmo_s       = 1'b0;
    if ((state_r == FETCH) || (state_r == MEM_READ) || (state_r == MEM_WRITE)) begin
      mem_state_s = 1'b1;
    end else begin
      mem_state_s = 1'b0;
    end
    if ((MEM_TIMEOUT > 0) && mem_state_s && !mem_ready && (cnt_r == TMO_LAST)) begin
      tmo_s = 1'b1;
    end else begin
      tmo_s = 1'b0;
    end
  end

  // Wait counter: counts stalled memory cycles, clears on any state change,
  // ready, or abort (an abort out of FETCH re-enters FETCH with a fresh budget).
  always_comb begin
    cnt_nxt_s = '0;
    if ((next_state_s != state_r) || mem_ready || tmo_s) begin
      cnt_nxt_s = '0;
    end else if (mem_state_s && (MEM_TIMEOUT > 0)) begin
      cnt_nxt_s = cnt_r + CNT_W'(1);
    end else begin
      cnt_nxt_s = '0;
    end
  end

  // Next-state and control decode; everything is held at zero while rst is high.
  always_comb begin
    next_state_s  = state_r;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    instr_done    = 1'b0;
    illegal_op    = 1'b0;
    mem_error     = 1'b0;
    if (!rst) begin
      case (state_r)
        FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          if (mem_ready) begin
            ir_write     = 1'b1;
            pc_write     = 1'b1;
            next_state_s = DECODE;
          end else if (tmo_s) begin
            mem_error    = 1'b1;
            next_state_s = FETCH;
          end else begin
            next_state_s = FETCH;
          end
        end
        DECODE: begin
          alu_src_b = 2'b11;
          case (opcode)
            OP_LW, OP_SW: next_state_s = MEM_ADDR;
            OP_RTYPE:     next_state_s = EXECUTE;
            OP_BEQ:       next_state_s = BRANCH;
            OP_J:         next_state_s = JUMP;
            default: begin
              illegal_op   = 1'b1;
              next_state_s = FETCH;
            end
          endcase
        end
        MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          if (opcode == OP_LW) begin
            next_state_s = MEM_READ;
          end else begin
            next_state_s = MEM_WRITE;
          end
        end
        MEM_READ: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
          if (mem_ready) begin
            next_state_s = MEM_WB;
          end else if (tmo_s) begin
            mem_error    = 1'b1;
            next_state_s = FETCH;
          end else begin
            next_state_s = MEM_READ;
          end
        end
        MEM_WB: begin
          reg_write    = 1'b1;
          mem_to_reg   = 1'b1;
          instr_done   = 1'b1;
          next_state_s = FETCH;
        end
        MEM_WRITE: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
          if (mem_ready) begin
            instr_done   = 1'b1;
            next_state_s = FETCH;
          end else if (tmo_s) begin
            mem_error    = 1'b1;
            next_state_s = FETCH;
          end else begin
            next_state_s = MEM_WRITE;
          end
        end
        EXECUTE: begin
          alu_src_a    = 1'b1;
          alu_op       = 2'b10;
          next_state_s = R_COMPLETE;
        end
        R_COMPLETE: begin
          reg_write    = 1'b1;
          reg_dst      = 1'b1;
          instr_done   = 1'b1;
          next_state_s = FETCH;
        end
        BRANCH: begin
          // zero is applied in the datapath: pc_write | (pc_write_cond & zero).
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
          instr_done    = 1'b1;
          next_state_s  = FETCH;
        end
        JUMP: begin
          pc_write     = 1'b1;
          pc_source    = 2'b10;
          instr_done   = 1'b1;
          next_state_s = FETCH;
        end
        default: begin
          next_state_s = FETCH;
        end
      endcase
    end else begin
      next_state_s = FETCH;
    end
  end

  // zero is consumed by the datapath, not by this controller.
  logic unused_s;
  assign unused_s = zero;

endmodule
